// File: rtl/pyc_byte_mem_arb_pkg.sv
// rtl/pyc_byte_mem_arb_pkg.sv - shared constants for the two-port byte memory arbiter
// Contents:
//   pyc_state_t  FSM state encoding (IDLE=0, ACCESS=1, RESP=2), visible to benches
//   NUM_PORTS    number of requester ports
//   grant_index  converts a one-hot two-port grant into a port index
package pyc_byte_mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } pyc_state_t;

  localparam int NUM_PORTS = 2;

  function automatic logic grant_index(input logic [NUM_PORTS-1:0] grant);
    return grant[1];
  endfunction

endpackage

// File: rtl/pyc_rr_arb2.sv
// rtl/pyc_rr_arb2.sv - two-way round-robin picker with last-grant pointer
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   valid[1:0]      requesters currently asking
//   last            index of the port accepted this cycle
//   advance         a grant was accepted; record last into the pointer
//   grant[1:0]      one-hot winner (0 when nobody is valid)
module pyc_rr_arb2
  import pyc_byte_mem_arb_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_PORTS-1:0] valid,
  input  logic                 last,
  input  logic                 advance,
  output logic [NUM_PORTS-1:0] grant
);

  // Index of the port granted most recently. Resetting to 1 makes port 0
  // the winner of the first tie.
  logic last_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= 1'b1;
    end else if (advance) begin
      last_q <= last;
    end
  end

  always_comb begin
    grant = valid;
    if (valid == 2'b11) begin
      grant = last_q ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/pyc_byte_mem_arb.sv
// rtl/pyc_byte_mem_arb.sv - two-requester arbiter onto a single-port byte memory
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   rN_req_valid/ready              request handshake, N = 0, 1
//   rN_req_write/addr/wdata/wstrb   request payload
//   rN_resp_valid/ready             response handshake
//   rN_resp_rdata                   read data (0 for writes, 0 for non-owner)
//   mem_raddr, mem_rdata            memory read port (combinational data)
//   mem_wvalid/waddr/wdata/wstrb    memory write port
module pyc_byte_mem_arb
  import pyc_byte_mem_arb_pkg::*;
#(
  parameter  int ADDR_WIDTH = 64,
  parameter  int DATA_WIDTH = 64,
  localparam int STRB_WIDTH = (DATA_WIDTH + 7) / 8
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  r0_req_valid,
  output logic                  r0_req_ready,
  input  logic                  r0_req_write,
  input  logic [ADDR_WIDTH-1:0] r0_req_addr,
  input  logic [DATA_WIDTH-1:0] r0_req_wdata,
  input  logic [STRB_WIDTH-1:0] r0_req_wstrb,
  output logic                  r0_resp_valid,
  input  logic                  r0_resp_ready,
  output logic [DATA_WIDTH-1:0] r0_resp_rdata,

  input  logic                  r1_req_valid,
  output logic                  r1_req_ready,
  input  logic                  r1_req_write,
  input  logic [ADDR_WIDTH-1:0] r1_req_addr,
  input  logic [DATA_WIDTH-1:0] r1_req_wdata,
  input  logic [STRB_WIDTH-1:0] r1_req_wstrb,
  output logic                  r1_resp_valid,
  input  logic                  r1_resp_ready,
  output logic [DATA_WIDTH-1:0] r1_resp_rdata,

  output logic [ADDR_WIDTH-1:0] mem_raddr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  mem_wvalid,
  output logic [ADDR_WIDTH-1:0] mem_waddr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [STRB_WIDTH-1:0] mem_wstrb
);

  pyc_state_t            state;
  logic                  owner_q;
  logic                  write_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_WIDTH-1:0] wstrb_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic [NUM_PORTS-1:0]  req_valid;
  logic [NUM_PORTS-1:0]  grant;
  logic [NUM_PORTS-1:0]  req_ready;
  logic                  req_hs;
  logic                  win;
  logic                  resp_hs;

  assign req_valid = {r1_req_valid, r0_req_valid};

  pyc_rr_arb2 u_rr (
    .clk     (clk),
    .rst     (rst),
    .valid   (req_valid),
    .last    (win),
    .advance (req_hs),
    .grant   (grant)
  );

  // Readies are masked by rst so nothing is accepted in a reset cycle,
  // which also keeps the arbiter pointer from moving.
  assign req_ready = grant & {NUM_PORTS{(state == ST_IDLE) && !rst}};
  assign req_hs    = |(req_valid & req_ready);
  assign win       = grant_index(req_ready);
  assign resp_hs   = (state == ST_RESP) && (owner_q ? r1_resp_ready : r0_resp_ready);

  assign r0_req_ready = req_ready[0];
  assign r1_req_ready = req_ready[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      owner_q <= 1'b0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_hs) begin
            owner_q <= win;
            write_q <= win ? r1_req_write : r0_req_write;
            addr_q  <= win ? r1_req_addr  : r0_req_addr;
            wdata_q <= win ? r1_req_wdata : r0_req_wdata;
            wstrb_q <= win ? r1_req_wstrb : r0_req_wstrb;
            state   <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          rdata_q <= write_q ? '0 : mem_rdata;
          state   <= ST_RESP;
        end
        ST_RESP: begin
          if (resp_hs) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // The latched request only changes on acceptance, so outside ACCESS the
  // memory port naturally holds the values of the last access.
  assign mem_raddr  = addr_q;
  assign mem_waddr  = addr_q;
  assign mem_wdata  = wdata_q;
  assign mem_wstrb  = wstrb_q;
  assign mem_wvalid = (state == ST_ACCESS) && write_q && !rst;

  // Response data is exposed only to the owner while in RESP so a stale
  // value from another port's transaction never leaks.
  assign r0_resp_valid = (state == ST_RESP) && !owner_q && !rst;
  assign r1_resp_valid = (state == ST_RESP) &&  owner_q && !rst;
  assign r0_resp_rdata = ((state == ST_RESP) && !owner_q) ? rdata_q : '0;
  assign r1_resp_rdata = ((state == ST_RESP) &&  owner_q) ? rdata_q : '0;

endmodule

// File: tb/tb_pyc_byte_mem_arb.sv
// tb/tb_pyc_byte_mem_arb.sv - directed self-checking bench for pyc_byte_mem_arb
module tb_pyc_byte_mem_arb;
  import pyc_byte_mem_arb_pkg::*;

  localparam int AW = 64;
  localparam int DW = 64;
  localparam int SW = 8;

  localparam logic [63:0] D1      = 64'h1122334455667788;
  localparam logic [63:0] D_PART  = 64'hAAAAAAAABBBBBBBB;
  localparam logic [63:0] EXP_PRT = 64'h00000000BBBBBBBB;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          r0_req_valid = 0, r0_req_write = 0, r0_resp_ready = 0;
  logic [AW-1:0] r0_req_addr = '0;
  logic [DW-1:0] r0_req_wdata = '0;
  logic [SW-1:0] r0_req_wstrb = '0;
  logic          r0_req_ready, r0_resp_valid;
  logic [DW-1:0] r0_resp_rdata;

  logic          r1_req_valid = 0, r1_req_write = 0, r1_resp_ready = 0;
  logic [AW-1:0] r1_req_addr = '0;
  logic [DW-1:0] r1_req_wdata = '0;
  logic [SW-1:0] r1_req_wstrb = '0;
  logic          r1_req_ready, r1_resp_valid;
  logic [DW-1:0] r1_resp_rdata;

  logic [AW-1:0] mem_raddr, mem_waddr;
  logic [DW-1:0] mem_rdata, mem_wdata;
  logic          mem_wvalid;
  logic [SW-1:0] mem_wstrb;

  int checks = 0;
  int errors = 0;

  pyc_byte_mem_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .r0_req_valid(r0_req_valid), .r0_req_ready(r0_req_ready), .r0_req_write(r0_req_write),
    .r0_req_addr(r0_req_addr), .r0_req_wdata(r0_req_wdata), .r0_req_wstrb(r0_req_wstrb),
    .r0_resp_valid(r0_resp_valid), .r0_resp_ready(r0_resp_ready), .r0_resp_rdata(r0_resp_rdata),
    .r1_req_valid(r1_req_valid), .r1_req_ready(r1_req_ready), .r1_req_write(r1_req_write),
    .r1_req_addr(r1_req_addr), .r1_req_wdata(r1_req_wdata), .r1_req_wstrb(r1_req_wstrb),
    .r1_resp_valid(r1_resp_valid), .r1_resp_ready(r1_resp_ready), .r1_resp_rdata(r1_resp_rdata),
    .mem_raddr(mem_raddr), .mem_rdata(mem_rdata), .mem_wvalid(mem_wvalid),
    .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb)
  );

  // Memory model: 128 words of 64 bits, combinational read, byte-strobed write.
  logic [63:0] mem [0:127];
  int          wr_pulses = 0;
  logic [7:0]  last_wstrb = '0;

  initial for (int i = 0; i < 128; i++) mem[i] = '0;

  assign mem_rdata = mem[mem_raddr[9:3]];

  always @(posedge clk) begin
    if (mem_wvalid) begin
      wr_pulses  <= wr_pulses + 1;
      last_wstrb <= mem_wstrb;
      for (int b = 0; b < 8; b++)
        if (mem_wstrb[b]) mem[mem_waddr[9:3]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic set_req(input int p, input logic v, input logic w, input logic [63:0] a,
                         input logic [63:0] d, input logic [7:0] s);
    if (p == 0) begin
      r0_req_valid = v; r0_req_write = w; r0_req_addr = a; r0_req_wdata = d; r0_req_wstrb = s;
    end else begin
      r1_req_valid = v; r1_req_write = w; r1_req_addr = a; r1_req_wdata = d; r1_req_wstrb = s;
    end
  endtask

  function automatic logic ready_of(input int p);
    return (p == 0) ? r0_req_ready : r1_req_ready;
  endfunction

  function automatic logic resp_valid_of(input int p);
    return (p == 0) ? r0_resp_valid : r1_resp_valid;
  endfunction

  function automatic logic [63:0] rdata_of(input int p);
    return (p == 0) ? r0_resp_rdata : r1_resp_rdata;
  endfunction

  // Runs one transaction with resp_ready held high. lat is the number of
  // cycles from acceptance to resp_valid (-1 if it never came).
  task automatic txn(input int p, input logic w, input logic [63:0] a, input logic [63:0] d,
                     input logic [7:0] s, output logic [63:0] rd, output int lat);
    bit got = 0;
    rd  = '0;
    lat = -1;
    set_req(p, 1'b1, w, a, d, s);
    if (p == 0) r0_resp_ready = 1'b1; else r1_resp_ready = 1'b1;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      if (ready_of(p)) got = 1;
    end
    if (!got) begin
      set_req(p, 1'b0, w, a, d, s);
      return;
    end
    @(posedge clk); #1;
    set_req(p, 1'b0, w, a, d, s);
    for (int k = 1; k <= 10 && lat < 0; k++) begin
      @(negedge clk);
      if (resp_valid_of(p)) begin
        lat = k;
        rd  = rdata_of(p);
      end
    end
    if (lat >= 0) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    set_req(0, 1'b1, 1'b0, 64'h8, '0, '0);
    set_req(1, 1'b1, 1'b0, 64'h8, '0, '0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (r0_req_ready !== 1'b0 || r1_req_ready !== 1'b0) begin
      errors++; $display("FAIL reset_ready: got %b%b expected 00", r1_req_ready, r0_req_ready);
    end
    checks++;
    if (r0_resp_valid !== 1'b0 || r1_resp_valid !== 1'b0 || mem_wvalid !== 1'b0) begin
      errors++; $display("FAIL reset_valids: got resp %b%b wvalid %b expected 0", r1_resp_valid, r0_resp_valid, mem_wvalid);
    end
    checks++;
    if (mem_raddr !== '0 || mem_wstrb !== '0 || mem_wdata !== '0) begin
      errors++; $display("FAIL reset_latched: got raddr %h wstrb %h wdata %h expected 0", mem_raddr, mem_wstrb, mem_wdata);
    end
    checks++;
    if (dut.state !== ST_IDLE) begin
      errors++; $display("FAIL reset_state: got %0d expected %0d", dut.state, ST_IDLE);
    end
    set_req(0, 1'b0, 1'b0, '0, '0, '0);
    set_req(1, 1'b0, 1'b0, '0, '0, '0);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_round_robin;
    int g[$];
    bit both = 0;
    set_req(0, 1'b1, 1'b0, 64'h0, '0, '0);
    set_req(1, 1'b1, 1'b0, 64'h8, '0, '0);
    r0_resp_ready = 1'b1;
    r1_resp_ready = 1'b1;
    for (int n = 0; n < 60 && g.size() < 4; n++) begin
      @(negedge clk);
      if (r0_req_ready && r1_req_ready) both = 1;
      if (r0_req_ready) g.push_back(0);
      else if (r1_req_ready) g.push_back(1);
    end
    @(posedge clk); #1;
    set_req(0, 1'b0, 1'b0, '0, '0, '0);
    set_req(1, 1'b0, 1'b0, '0, '0, '0);
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (g.size() != 4) begin
      errors++; $display("FAIL rr_count: got %0d grants expected 4", g.size());
    end
    for (int i = 0; i < g.size(); i++) begin
      checks++;
      if (g[i] != (i % 2)) begin
        errors++; $display("FAIL rr_order[%0d]: got port %0d expected port %0d", i, g[i], i % 2);
      end
    end
    checks++;
    if (both) begin
      errors++; $display("FAIL rr_exclusive: got both readies high expected at most one");
    end
  endtask

  task automatic test_write_read;
    logic [63:0] rd;
    int lat;
    int p0 = wr_pulses;
    txn(0, 1'b1, 64'h10, D1, 8'hFF, rd, lat);
    checks++;
    if (lat != 2) begin
      errors++; $display("FAIL wr_latency: got %0d expected 2", lat);
    end
    checks++;
    if (rd !== 64'h0) begin
      errors++; $display("FAIL wr_rdata: got %h expected 0", rd);
    end
    checks++;
    if (wr_pulses != p0 + 1 || mem[2] !== D1) begin
      errors++; $display("FAIL wr_mem: got pulses %0d word %h expected %0d %h", wr_pulses - p0, mem[2], 1, D1);
    end
    txn(0, 1'b0, 64'h10, '0, '0, rd, lat);
    checks++;
    if (lat != 2) begin
      errors++; $display("FAIL rd_latency: got %0d expected 2", lat);
    end
    checks++;
    if (rd !== D1) begin
      errors++; $display("FAIL rd_data: got %h expected %h", rd, D1);
    end
    checks++;
    if (wr_pulses != p0 + 1) begin
      errors++; $display("FAIL rd_no_write: got %0d pulses expected 1", wr_pulses - p0);
    end
  endtask

  task automatic test_partial_strobe;
    logic [63:0] rd;
    int lat;
    txn(1, 1'b1, 64'h20, D_PART, 8'h0F, rd, lat);
    checks++;
    if (lat != 2) begin
      errors++; $display("FAIL part_wr_latency: got %0d expected 2", lat);
    end
    txn(1, 1'b0, 64'h20, '0, '0, rd, lat);
    checks++;
    if (rd !== EXP_PRT) begin
      errors++; $display("FAIL part_rdata: got %h expected %h", rd, EXP_PRT);
    end
  endtask

  task automatic test_zero_strobe;
    logic [63:0] rd;
    int lat;
    int p0 = wr_pulses;
    txn(0, 1'b1, 64'h10, 64'hFFFFFFFFFFFFFFFF, 8'h00, rd, lat);
    checks++;
    if (lat != 2 || rd !== 64'h0) begin
      errors++; $display("FAIL zstrb_resp: got lat %0d rdata %h expected 2 0", lat, rd);
    end
    checks++;
    if (wr_pulses != p0 + 1 || last_wstrb !== 8'h00) begin
      errors++; $display("FAIL zstrb_pulse: got %0d pulses wstrb %h expected 1 00", wr_pulses - p0, last_wstrb);
    end
    checks++;
    if (mem[2] !== D1) begin
      errors++; $display("FAIL zstrb_mem: got %h expected %h", mem[2], D1);
    end
  endtask

  task automatic test_resp_hold;
    bit got = 0, r0_rdy = 0, stable = 1, leak = 0;
    int lat = -1;
    logic [63:0] held = '0;
    r1_resp_ready = 1'b0;
    set_req(1, 1'b1, 1'b0, 64'h10, '0, '0);
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      if (r1_req_ready) got = 1;
    end
    checks++;
    if (!got) begin
      errors++; $display("FAIL hold_accept: got no ready expected r1 accepted");
      set_req(1, 1'b0, 1'b0, '0, '0, '0);
      return;
    end
    @(posedge clk); #1;
    set_req(1, 1'b0, 1'b0, '0, '0, '0);
    set_req(0, 1'b1, 1'b0, 64'h20, '0, '0);
    r0_resp_ready = 1'b1;
    for (int k = 1; k <= 10 && lat < 0; k++) begin
      @(negedge clk);
      if (r0_req_ready) r0_rdy = 1;
      if (r1_resp_valid) begin
        lat  = k;
        held = r1_resp_rdata;
      end
    end
    checks++;
    if (lat != 2 || held !== D1) begin
      errors++; $display("FAIL hold_first: got lat %0d rdata %h expected 2 %h", lat, held, D1);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (r1_resp_valid !== 1'b1 || r1_resp_rdata !== held) stable = 0;
      if (r0_req_ready) r0_rdy = 1;
      if (r0_resp_valid !== 1'b0 || r0_resp_rdata !== '0) leak = 1;
    end
    checks++;
    if (!stable) begin
      errors++; $display("FAIL hold_stable: got unstable response expected valid with %h", held);
    end
    checks++;
    if (r0_rdy) begin
      errors++; $display("FAIL hold_r0_ready: got r0_req_ready 1 expected 0");
    end
    checks++;
    if (leak) begin
      errors++; $display("FAIL hold_nonowner: got r0 response activity expected none");
    end
    r1_resp_ready = 1'b1;
    @(posedge clk); #1;
    r1_resp_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (r0_req_ready !== 1'b1 || r1_resp_valid !== 1'b0) begin
      errors++; $display("FAIL hold_release: got r0_ready %b r1_resp_valid %b expected 1 0", r0_req_ready, r1_resp_valid);
    end
    @(posedge clk); #1;
    set_req(0, 1'b0, 1'b0, '0, '0, '0);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (r0_resp_valid !== 1'b1 || r0_resp_rdata !== EXP_PRT) begin
      errors++; $display("FAIL hold_r0_resp: got valid %b rdata %h expected 1 %h", r0_resp_valid, r0_resp_rdata, EXP_PRT);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_in_access;
    bit got = 0, rv = 0;
    int p0 = wr_pulses;
    set_req(0, 1'b1, 1'b1, 64'h30, 64'hDEADBEEFCAFEF00D, 8'hFF);
    r0_resp_ready = 1'b1;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      if (r0_req_ready) got = 1;
    end
    checks++;
    if (!got) begin
      errors++; $display("FAIL rstacc_accept: got no ready expected r0 accepted");
    end
    @(posedge clk); #1;
    rst = 1'b1;
    set_req(0, 1'b0, 1'b0, '0, '0, '0);
    @(negedge clk);
    checks++;
    if (mem_wvalid !== 1'b0) begin
      errors++; $display("FAIL rstacc_wvalid: got %b expected 0", mem_wvalid);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (r0_resp_valid || r1_resp_valid) rv = 1;
    end
    checks++;
    if (rv) begin
      errors++; $display("FAIL rstacc_resp: got resp_valid expected none");
    end
    checks++;
    if (wr_pulses != p0 || mem[6] !== 64'h0) begin
      errors++; $display("FAIL rstacc_mem: got pulses %0d word %h expected 0 0", wr_pulses - p0, mem[6]);
    end
    checks++;
    if (dut.state !== ST_IDLE) begin
      errors++; $display("FAIL rstacc_state: got %0d expected %0d", dut.state, ST_IDLE);
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_write_read();
    test_partial_strobe();
    test_zero_strobe();
    test_resp_hold();
    test_reset_in_access();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pyc_byte_mem_arb.md
PYC_BYTE_MEM_ARB -- requirements
Module: pyc_byte_mem_arb

Interface
REQ-001 The module SHALL have parameter ADDR_WIDTH, default 64, byte-address width.
REQ-002 The module SHALL have parameter DATA_WIDTH, default 64, data width in bits; STRB_WIDTH = (DATA_WIDTH+7)/8 is derived, not overridable.
REQ-003 The module SHALL have the following ports; every port prefixed rN_ exists once per requester, N = 0 and 1:
  clk  input  1  clock, all state on posedge
  rst  input  1  reset: synchronous, active-high
  rN_req_valid  input  1  request pending
  rN_req_ready  output  1  request accepted this cycle
  rN_req_write  input  1  1 = write, 0 = read
  rN_req_addr  input  ADDR_WIDTH  byte address
  rN_req_wdata  input  DATA_WIDTH  write data, little-endian
  rN_req_wstrb  input  STRB_WIDTH  byte enables
  rN_resp_valid  output  1  response available
  rN_resp_ready  input  1  response consumed
  rN_resp_rdata  output  DATA_WIDTH  read data; 0 for writes
  mem_raddr  output  ADDR_WIDTH  to memory read address
  mem_rdata  input  DATA_WIDTH  combinational read data from memory
  mem_wvalid  output  1  memory write strobe
  mem_waddr  output  ADDR_WIDTH  memory write address
  mem_wdata  output  DATA_WIDTH  memory write data
  mem_wstrb  output  STRB_WIDTH  memory byte enables

Function
REQ-004 The block SHALL be a 3-state FSM: IDLE, ACCESS, RESP; exactly one transaction in flight.
REQ-005 In IDLE, rN_req_ready SHALL be 1 only for the arbitration winner among valid requesters; both readies are 0 in ACCESS and RESP.
REQ-006 Arbitration SHALL be round-robin: one valid requester wins; if both valid, the port not granted last wins; the last-grant pointer updates only on an accepted handshake.
REQ-007 On handshake (valid & ready), the block SHALL latch owner, write flag, addr, wdata, wstrb and go IDLE -> ACCESS.
REQ-008 In ACCESS, mem_raddr and mem_waddr SHALL equal the latched addr; mem_wdata and mem_wstrb the latched values; mem_wvalid = latched write flag & !rst, asserted for exactly this one cycle.
REQ-009 Outside ACCESS, mem_wvalid SHALL be 0; mem_raddr, mem_waddr, mem_wdata and mem_wstrb SHALL hold their last values.
REQ-010 At the end of ACCESS, the response data register SHALL capture mem_rdata for reads and 0 for writes; ACCESS -> RESP unconditionally.
REQ-011 In RESP, rN_resp_valid SHALL be 1 only for the owner and held, with rN_resp_rdata stable, until rN_resp_ready; on that handshake the block goes RESP -> IDLE.
REQ-012 Latency SHALL be: request accepted in cycle T, resp_valid asserted in cycle T+2; next acceptance no earlier than the cycle after the response handshake.
REQ-013 The non-owner port SHALL see resp_valid = 0 and resp_rdata = 0 at all times.
REQ-014 The block SHALL not check address range; bounds handling belongs to the memory.
REQ-015 A write with wstrb = 0 SHALL still complete with a response; the memory sees mem_wvalid = 1 with zero strobes.

Reset
REQ-016 While rst = 1 at a posedge, the block SHALL go to IDLE, set the last-grant pointer so port 0 wins a tie next, and clear resp data and the latched registers to 0.
REQ-017 During and after reset, all readies, resp_valids and mem_wvalid SHALL be 0; an in-flight transaction is dropped with no response, and no write occurs if reset hits ACCESS.

Structure
REQ-018 The FSM state encodings (IDLE=0, ACCESS=1, RESP=2) SHALL be shared constants in the common pyc include package, for use by the bench.
REQ-019 The round-robin picker SHALL be a sub-module pyc_rr_arb2: inputs valid[1:0], last, advance; outputs grant[1:0]; it holds the pointer register.

Verification
REQ-020 Bench: r0 writes addr 0x10, data 0x1122334455667788, wstrb 0xFF; then r0 reads 0x10 -> r0_resp_valid at T+2, rdata 0x1122334455667788.
REQ-021 Bench: r0 and r1 both hold valid continuously after reset -> grant order 0,1,0,1 over four transactions.
REQ-022 Bench: write wstrb 0x0F data 0xAAAAAAAABBBBBBBB over 0 contents, then read -> rdata 0x00000000BBBBBBBB.
REQ-023 Bench: hold r1_resp_ready = 0 for 5 cycles in RESP -> resp_valid and rdata stable; r0_req_ready stays 0 throughout.
REQ-024 Bench: assert rst in the ACCESS cycle of a write -> mem_wvalid is 0, no resp_valid, memory unchanged, FSM in IDLE.
